// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/compare ops, shifts executed one bit per clock.
// Result and comparison/status flags are registered and held until the next completed operation.
module alu_multicycle #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             not_equal,
  output logic             lesser_than,
  output logic             greater_or_equal,
  output logic             unsigned_lesser,
  output logic             unsigned_greater_equal,
  output logic             overflow,
  output logic             carry
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  // Flag vector order: {eq, ne, lt, ge, ult, uge}
  function automatic logic [5:0] cmp_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic eq, lt, ult;
    eq  = (a == b);
    lt  = ($signed(a) < $signed(b));
    ult = (a < b);
    return {eq, !eq, lt, !lt, ult, !ult};
  endfunction

  // {overflow, carry}; carry on SUB is not-borrow
  function automatic logic [1:0] addsub_status(input logic [3:0] o, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    logic [WIDTH-1:0] diff;
    logic [1:0] st;
    st = 2'b00;
    if (o == OP_ADD) begin
      sum = {1'b0, a} + {1'b0, b};
      st  = {(a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]), sum[WIDTH]};
    end else if (o == OP_SUB) begin
      diff = a - b;
      st   = {(a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), (a >= b)};
    end
    return st;
  endfunction

  function automatic logic [WIDTH-1:0] single_res(input logic [3:0] o, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [SHAMT_W-1:0] sh;
    sh = b[SHAMT_W-1:0];
    case (o)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return WIDTH'($signed(a) < $signed(b));
      OP_SLTU: return WIDTH'(a < b);
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return WIDTH'($signed(a) >>> sh);
      default: return '0;
    endcase
  endfunction

  logic [1:0]         state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [7:0]         flags_q, flags_d;
  logic [WIDTH-1:0]   a_q, b_q, sh_q, sh_next;
  logic [3:0]         op_q;
  logic               accept, go_shift;

  assign accept   = start && (state_q != SHIFT);
  assign go_shift = accept && ((op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA))
                    && (B[SHAMT_W-1:0] != '0);

  always_comb begin
    case (op_q)
      OP_SLL:  sh_next = {sh_q[WIDTH-2:0], 1'b0};
      OP_SRL:  sh_next = {1'b0, sh_q[WIDTH-1:1]};
      default: sh_next = {a_q[WIDTH-1], sh_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      SHIFT: begin
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d  = DONE;
          result_d = sh_next;
          flags_d  = {cmp_flags(a_q, b_q), 2'b00};
        end
      end
      default: begin
        if (go_shift) begin
          state_d = SHIFT;
          cnt_d   = B[SHAMT_W-1:0];
        end else if (accept) begin
          state_d  = DONE;
          result_d = single_res(op, A, B);
          flags_d  = {cmp_flags(A, B), addsub_status(op, A, B)};
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Reset state mirrors A=B=0: equal, greater_or_equal, unsigned_greater_equal set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= 8'b1001_0100;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    if (go_shift) begin
      a_q  <= A;
      b_q  <= B;
      op_q <= op;
      sh_q <= A;
    end else if (state_q == SHIFT) begin
      sh_q <= sh_next;
    end
  end

  assign result = result_q;
  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign {equal, not_equal, lesser_than, greater_or_equal,
          unsigned_lesser, unsigned_greater_equal, overflow, carry} = flags_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=64): expected result/flags queued at issue, checked on done.
module tb_alu_multicycle;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] A = '0, B = '0;
  logic [W-1:0] result;
  logic busy, done, equal, not_equal, lesser_than, greater_or_equal;
  logic unsigned_lesser, unsigned_greater_equal, overflow, carry;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .result(result), .busy(busy), .done(done),
    .equal(equal), .not_equal(not_equal), .lesser_than(lesser_than),
    .greater_or_equal(greater_or_equal), .unsigned_lesser(unsigned_lesser),
    .unsigned_greater_equal(unsigned_greater_equal),
    .overflow(overflow), .carry(carry)
  );

  always #5 clk = ~clk;

  wire [7:0] flags = {equal, not_equal, lesser_than, greater_or_equal,
                      unsigned_lesser, unsigned_greater_equal, overflow, carry};

  logic [W-1:0] exp_res_q[$];
  logic [7:0]   exp_flg_q[$];
  int checks = 0, errors = 0;
  int busy_cnt = 0, done_run = 0, max_run = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Reference: flags {eq, ne, lt, ge, ult, uge, ov, cy}
  task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [7:0] f);
    logic [W:0] s;
    logic ov, cy;
    int n;
    n  = int'(b[5:0]);
    ov = 1'b0;
    cy = 1'b0;
    case (o)
      4'd0: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[W-1:0];
        cy = s[W];
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'd1: begin
        r  = a - b;
        cy = (a >= b);
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd6: r = (a < b) ? 64'd1 : 64'd0;
      4'd7: r = a << n;
      4'd8: r = a >> n;
      4'd9: r = $signed(a) >>> n;
      default: r = '0;
    endcase
    f = {a == b, a != b, $signed(a) < $signed(b), $signed(a) >= $signed(b),
         a < b, a >= b, ov, cy};
  endtask

  task automatic push(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [7:0] f;
    model(o, a, b, r, f);
    exp_res_q.push_back(r);
    exp_flg_q.push_back(f);
  endtask

  task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    busy_cnt = 0;
    push(o, a, b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && exp_res_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("completion_timeout", exp_res_q.size(), 0);
  endtask

  task automatic run(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int nbusy);
    send(o, a, b);
    wait_done();
    check_eq("busy_cycles", busy_cnt, nbusy);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_run++;
        if (done_run > max_run) max_run = done_run;
        check_eq("done_expected", exp_res_q.size() != 0, 1);
        if (exp_res_q.size() != 0) begin
          check_eq("sb_result", result, exp_res_q.pop_front());
          check_eq("sb_flags", flags, exp_flg_q.pop_front());
        end
      end else begin
        done_run = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0]   ro;
    repeat (2) @(negedge clk);
    check_eq("rst_result", result, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_flags", flags, 8'h94);
    rst_n = 1'b1;

    run(4'd0, 64'd10, 64'd10, 0);
    check_eq("add_res", result, 64'd20);
    check_eq("add_carry", carry, 0);
    check_eq("add_ovf", overflow, 0);

    run(4'd1, 64'd30, 64'd40, 0);
    check_eq("sub_res", result, 64'hFFFF_FFFF_FFFF_FFF6);
    check_eq("sub_lt", lesser_than, 1);
    check_eq("sub_ult", unsigned_lesser, 1);
    check_eq("sub_ne", not_equal, 1);
    check_eq("sub_carry", carry, 0);

    // SRA with a start request presented while busy
    @(negedge clk);
    op = 4'd9; A = 64'hFFFF_FFFF_FFFF_FFF0; B = 64'd2; start = 1'b1;
    busy_cnt = 0;
    push(4'd9, A, B);
    @(negedge clk);
    op = 4'd0; A = 64'd1; B = 64'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check_eq("sra_busy", busy_cnt, 2);
    check_eq("sra_res", result, 64'hFFFF_FFFF_FFFF_FFFC);

    run(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
    check_eq("ovf_res", result, 64'h8000_0000_0000_0000);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_carry", carry, 0);

    run(4'd6, 64'd80, -64'sd8, 0);
    check_eq("sltu_res", result, 64'd1);
    check_eq("sltu_ult", unsigned_lesser, 1);
    check_eq("sltu_lt", lesser_than, 0);

    run(4'd1, 64'd5, 64'd5, 0);
    check_eq("sub_eq_carry", carry, 1);
    check_eq("sub_eq_equal", equal, 1);
    run(4'd12, 64'd3, 64'd4, 0);
    check_eq("reserved_res", result, 64'd0);
    run(4'd7, 64'h1234, 64'd64, 0);
    check_eq("sll0_res", result, 64'h1234);
    run(4'd8, 64'h8000_0000_0000_0000, 64'd3, 3);
    check_eq("srl_res", result, 64'h1000_0000_0000_0000);
    run(4'd5, -64'sd1, 64'd1, 0);
    check_eq("slt_res", result, 64'd1);
    check_eq("single_done_run", max_run, 1);

    for (int i = 0; i < 16; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run(ro, ra, rb, (ro >= 4'd7 && ro <= 4'd9) ? int'(rb[5:0]) : 0);
    end

    // Reset in the middle of a long shift aborts it
    @(negedge clk);
    op = 4'd7; A = 64'd1; B = 64'd63; start = 1'b1;
    busy_cnt = 0;
    push(4'd7, A, B);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && busy_cnt < 10; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("abort_busy_seen", busy_cnt, 10);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_result", result, 0);
    check_eq("abort_flags", flags, 8'h94);
    exp_res_q.delete();
    exp_flg_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    run(4'd7, 64'd1, 64'h41, 1);
    check_eq("sll_after_rst", result, 64'd2);

    // Back-to-back accepted requests
    max_run = 0;
    @(negedge clk);
    op = 4'd0; A = 64'd10; B = 64'd10; start = 1'b1;
    push(op, A, B);
    @(negedge clk);
    op = 4'd4; A = 64'hA5A5_0000_FFFF_1234; B = 64'h0F0F_1111_00FF_4321;
    push(op, A, B);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check_eq("b2b_done_run", max_run, 2);
    check_eq("b2b_xor_res", result, 64'hAAAA_1111_FF00_5115);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
